// File: rtl/imsic_msi_queue_gate.sv
// MSI delivery gate for one hart's IMSIC: queues incoming MSIs and applies them
// one per cycle to the per-file pending (eip) arrays, arbitrating against CSR
// claims and software eip writes without losing any MSI.
module imsic_msi_queue_gate #(
  parameter int unsigned NR_INTP_FILES   = 7,
  parameter int unsigned XLEN            = 64,
  parameter int unsigned NR_SRC          = 64,
  parameter int unsigned NR_HARTS_WIDTH  = 2,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned NR_SRC_WIDTH    = $clog2(NR_SRC),
  parameter int unsigned INTP_FILE_WIDTH = $clog2(NR_INTP_FILES),
  parameter int unsigned NR_REG          = (NR_SRC + XLEN - 1) / XLEN,
  parameter int unsigned MSI_INFO_WIDTH  = NR_HARTS_WIDTH + INTP_FILE_WIDTH + NR_SRC_WIDTH,
  parameter int unsigned CNT_WIDTH       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NR_HARTS_WIDTH-1:0]               hart_id,
  input  logic [MSI_INFO_WIDTH-1:0]               i_msi_info,
  input  logic                                    i_msi_vld,
  output logic                                    o_msi_rdy,
  input  logic                                    i_claim_vld,
  input  logic [INTP_FILE_WIDTH-1:0]              i_claim_file,
  input  logic [NR_SRC_WIDTH-1:0]                 i_claim_eid,
  input  logic [NR_INTP_FILES*NR_REG-1:0]         i_sw_wr,
  input  logic [NR_INTP_FILES*NR_REG*XLEN-1:0]    i_sw_data,
  output logic [NR_INTP_FILES*NR_REG*XLEN-1:0]    o_eip,
  output logic [CNT_WIDTH-1:0]                    o_fifo_cnt,
  output logic [7:0]                              o_drop_cnt
);

  localparam int unsigned NrTotReg = NR_INTP_FILES * NR_REG;
  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);

  logic [MSI_INFO_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic [7:0]                drop_q, drop_d;
  logic [XLEN-1:0]           eip_q [NrTotReg];
  logic [XLEN-1:0]           eip_d [NrTotReg];

  logic                       push, pop, head_vld, head_legal, head_stall, set_en;
  logic [MSI_INFO_WIDTH-1:0]  head;
  logic [NR_HARTS_WIDTH-1:0]  head_hart;
  logic [INTP_FILE_WIDTH-1:0] head_file;
  logic [NR_SRC_WIDTH-1:0]    head_eid;
  logic [31:0]                head_reg, head_bit, claim_reg, claim_bit;
  logic                       claim_legal;
  logic [XLEN-1:0]            set_mask, clr_mask;

  // Ready comes only from the registered count; a same-cycle pop does not help.
  assign o_msi_rdy  = (cnt_q < CNT_WIDTH'(FIFO_DEPTH));
  assign push       = i_msi_vld & o_msi_rdy;
  assign head_vld   = (cnt_q != '0);
  assign o_fifo_cnt = cnt_q;
  assign o_drop_cnt = drop_q;

  // Decode the queue head into {hart, file, eid} and its target register/bit.
  always_comb begin
    head       = fifo_mem_q[rd_ptr_q];
    head_hart  = head[MSI_INFO_WIDTH-1 -: NR_HARTS_WIDTH];
    head_file  = head[NR_SRC_WIDTH +: INTP_FILE_WIDTH];
    head_eid   = head[NR_SRC_WIDTH-1:0];
    head_legal = (head_hart == hart_id) && (head_eid != '0) &&
                 (32'(head_eid) < NR_SRC) && (32'(head_file) < NR_INTP_FILES);
    head_reg   = 32'(head_file) * NR_REG + 32'(head_eid) / XLEN;
    head_bit   = 32'(head_eid) % XLEN;
    set_mask   = XLEN'(1) << head_bit;

    claim_legal = i_claim_vld && (i_claim_eid != '0) &&
                  (32'(i_claim_eid) < NR_SRC) && (32'(i_claim_file) < NR_INTP_FILES);
    claim_reg   = 32'(i_claim_file) * NR_REG + 32'(i_claim_eid) / XLEN;
    claim_bit   = 32'(i_claim_eid) % XLEN;
    clr_mask    = XLEN'(1) << claim_bit;
  end

  // A legal head whose register is being written by software waits one cycle.
  always_comb begin
    head_stall = 1'b0;
    for (int unsigned r = 0; r < NrTotReg; r++) begin
      if ((32'(r) == head_reg) && i_sw_wr[r]) head_stall = 1'b1;
    end
    head_stall = head_stall & head_vld & head_legal;
    pop        = head_vld & ~head_stall;
    set_en     = pop & head_legal;
  end

  // Next eip: software write wins over claim; the set is applied after the claim
  // clear so an MSI racing a claim of the same bit survives.
  always_comb begin
    for (int unsigned r = 0; r < NrTotReg; r++) begin
      eip_d[r] = eip_q[r];
      if (i_sw_wr[r]) begin
        eip_d[r] = i_sw_data[r*XLEN +: XLEN];
      end else begin
        if (claim_legal && (claim_reg == 32'(r))) eip_d[r] = eip_d[r] & ~clr_mask;
        if (set_en && (head_reg == 32'(r)))       eip_d[r] = eip_d[r] | set_mask;
      end
    end
  end

  // Occupancy and saturating drop counter.
  always_comb begin
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_WIDTH'(1);
      2'b01:   cnt_d = cnt_q - CNT_WIDTH'(1);
      default: cnt_d = cnt_q;
    endcase
    drop_d = drop_q;
    if (pop && !head_legal && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  // Pack the eip registers onto the flat output bus.
  always_comb begin
    o_eip = '0;
    for (int unsigned r = 0; r < NrTotReg; r++) o_eip[r*XLEN +: XLEN] = eip_q[r];
  end

  // Control state and eip registers; reset discards anything still queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      drop_q   <= '0;
      for (int unsigned r = 0; r < NrTotReg; r++) eip_q[r] <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
      for (int unsigned r = 0; r < NrTotReg; r++) eip_q[r] <= eip_d[r];
    end
  end

  // Queue storage needs no reset; the count qualifies its contents.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= i_msi_info;
  end

endmodule

// File: doc/imsic_msi_queue_gate.md
Name: imsic_msi_queue_gate

Overview:
- Next-generation MSI delivery gate for one hart's IMSIC.
- Accepts MSIs over a valid/ready handshake into a parametrised FIFO, then applies them one per cycle to the pending-bit (eip) arrays of NR_INTP_FILES interrupt files.
- Arbitrates MSI sets against CSR claims and software eip writes without losing any MSI: conflicting MSIs are held, not dropped.
- Counts rejected MSIs. Sits between the MSI bus receiver and the per-file CSR register block.

Parameters:
- NR_INTP_FILES, 7, interrupt files (M, S, NR_INTP_FILES-2 VS).
- XLEN, 64, eip register width (32 or 64).
- NR_SRC, 64, interrupt identities per file, including reserved id 0.
- NR_HARTS_WIDTH, 2, hart-id field width.
- FIFO_DEPTH, 4, MSI queue entries; power of two, >=2.
- NR_SRC_WIDTH, $clog2(NR_SRC), derived.
- INTP_FILE_WIDTH, $clog2(NR_INTP_FILES), derived.
- NR_REG, ceil(NR_SRC/XLEN), derived; eip registers per file.
- MSI_INFO_WIDTH, NR_HARTS_WIDTH+INTP_FILE_WIDTH+NR_SRC_WIDTH, derived.
- CNT_WIDTH, $clog2(FIFO_DEPTH)+1, derived.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- hart_id  in  NR_HARTS_WIDTH  this hart's id; quasi-static.
- i_msi_info  in  MSI_INFO_WIDTH  {hart, file, eid}, MSB to LSB.
- i_msi_vld  in  1  MSI offer.
- o_msi_rdy  out  1  queue can accept.
- i_claim_vld  in  1  claim pulse from CSR block.
- i_claim_file  in  INTP_FILE_WIDTH  file being claimed.
- i_claim_eid  in  NR_SRC_WIDTH  identity being claimed.
- i_sw_wr  in  NR_INTP_FILES*NR_REG  per-register software write strobes.
- i_sw_data  in  NR_INTP_FILES*NR_REG*XLEN  software write data; register r occupies bits [r*XLEN +: XLEN].
- o_eip  out  NR_INTP_FILES*NR_REG*XLEN  pending bits, same packing as i_sw_data.
- o_fifo_cnt  out  CNT_WIDTH  current queue occupancy.
- o_drop_cnt  out  8  rejected-MSI count; saturates at 255.

Behaviour:
- Reset (async, rst=1): FIFO empty, o_fifo_cnt=0, o_msi_rdy=1, o_eip all 0, o_drop_cnt=0. Reset asserted mid-operation discards queued MSIs immediately.
- Push: o_msi_rdy = (o_fifo_cnt < FIFO_DEPTH), derived from registered count only. A push while full is impossible because rdy=0; a pop in the same cycle does not raise rdy.
- Head decode: hart = top NR_HARTS_WIDTH bits, file = next INTP_FILE_WIDTH bits, eid = low NR_SRC_WIDTH bits. Register index = file*NR_REG + eid/XLEN; bit = eid%XLEN.
- Head is illegal if any of the following holds; an illegal head pops in one cycle with no eip change and o_drop_cnt += 1 (saturating):
  - hart != hart_id;
  - eid == 0;
  - eid >= NR_SRC;
  - file >= NR_INTP_FILES.
- Legal head with i_sw_wr set for its target register in the same cycle: stall (no pop) for that cycle. The software value is written. The head retries next cycle and then sets its bit on top of the software value.
- Otherwise a legal head pops and sets its bit at the clock edge.
- Claim: a claim with i_claim_eid in [1, NR_SRC-1] clears that bit in file i_claim_file, unless i_sw_wr is set for that register. Claims with out-of-range eid or file are ignored.
- Same bit claimed and set in the same cycle: final value 1, because the new MSI arrives after the claim read.
- Different bits in the same register may be claimed and set in one cycle; both take effect.
- Software write to a register with no head conflict: register = i_sw_data, then the claim clear for that register is suppressed.
- Throughput: one pop per cycle. Latency: push at edge t, head pops at edge t+1, o_eip updated after edge t+1 (2 cycles vld-to-visible). No bypass when the queue is empty.
- Pointers wrap modulo FIFO_DEPTH; o_fifo_cnt tracks push minus pop; simultaneous push and pop leaves the count unchanged.

Test Plan:
- Reset, then push {hart_id, file 1, eid 5}: o_msi_rdy=1 throughout; bit 5 of file 1 reg 0 reads 1 two cycles after the handshake; o_fifo_cnt returns to 0.
- Hold i_msi_vld for 6 back-to-back legal MSIs with FIFO_DEPTH=4 while stalling pops via repeated sw writes to the target register: rdy drops at cnt=4; no MSI is lost; all 6 bits end up set.
- Push eid 0, eid NR_SRC, wrong hart and file 7 (with 7 files): o_eip unchanged; o_drop_cnt=4; then 300 illegal MSIs give o_drop_cnt=255.
- Same cycle: head sets file 0 eid 9 while a claim targets file 0 eid 9 (previously 1): result 1. Repeat with a claim of eid 10: eid 10 cleared and eid 9 set.
- sw write of 0 to file 2 reg 0 while the head targets file 2 eid 3: cycle 1 reg=0 and head stalled; cycle 2 bit 3=1, all other bits 0.
- Assert rst with 3 MSIs queued and eip non-zero: o_fifo_cnt, o_eip and o_drop_cnt read 0 immediately; no stale MSI is applied after release.
